axicb_scfifo_hs: RTL and testbench

- Next-generation single-clock FIFO for the AXI crossbar, replacing raw push/pull/full/empty with a valid/ready stream on both sides.
- Adds a fill level, programmable almost-full/almost-empty flags, a per-beat last flag and optional packet-store mode.
- Sits on crossbar channel paths (AW/W/B/AR/R buffering) between master/slave interfaces and the switching logic.

---
 rtl/axicb_scfifo_hs_if.sv | 25 ++
 rtl/axicb_scfifo_hs.sv | 121 ++++++++++++
 tb/tb_axicb_scfifo_hs.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axicb_scfifo_hs_if.sv
// Valid/ready stream bundle for axicb_scfifo_hs.
// The "in" side runs from producer to FIFO and the "out" side from FIFO to consumer.
// The slave modport is the FIFO's view and the master modport is the environment's view.
interface axicb_scfifo_hs_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/axicb_scfifo_hs.sv
// Single-clock valid/ready FIFO for crossbar channel buffering.
//
// Features:
// - The head is presented first-word fall-through.
// - The fill level and the almost-full/almost-empty flags are derived from the
//   registered pointers.
// - An optional pass-thru path is available when the FIFO is empty.
//
// Optional packet-store mode, selected by defining AXICB_SCFIFO_PKT_EN:
// - The read side only sees beats up to the last committed packet boundary.
// - A single packet that fills the FIFO is force-committed so that it drains
//   cut-through.
//
// Reset and clear:
// - aresetn (active low), srst and flush each clear the pointers synchronously.
module axicb_scfifo_hs #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 8,
  parameter bit PASS_THRU     = 1'b0,
  parameter int AFULL_THRESH  = 2**ADDR_WIDTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   srst,
  input  logic                   flush,
  axicb_scfifo_hs_if.slave       hs,
  output logic [ADDR_WIDTH:0]    level,
  output logic                   almost_full,
  output logic                   almost_empty
);

  localparam int                  DEPTH    = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] AFULL_L  = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_L = AEMPTY_THRESH[ADDR_WIDTH:0];

  logic                  clear;
  logic                  full;
  logic                  pt_active;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH:0]   wrptr_reg;
  logic [ADDR_WIDTH:0]   rdptr_reg;
  logic [ADDR_WIDTH:0]   vis_level;
  logic [DATA_WIDTH:0]   head;
  logic [DATA_WIDTH:0]   mem_reg [DEPTH];

  // Any of the three clear sources empties the FIFO. A clear wins over a transfer in the same cycle.
  assign clear = ~aresetn | srst | flush;

  // Pointers carry one extra MSB. The modulo difference therefore spans 0..DEPTH without ambiguity.
  assign level = wrptr_reg - rdptr_reg;
  assign full  = (level == DEPTH_L);
  assign head  = mem_reg[rdptr_reg[ADDR_WIDTH-1:0]];

  assign almost_full  = (level >= AFULL_L);
  assign almost_empty = (level <= AEMPTY_L);

`ifdef AXICB_SCFIFO_PKT_EN
  logic [ADDR_WIDTH:0] commit_reg;

  // The consumer only sees beats up to the packet boundary.
  assign vis_level = commit_reg - rdptr_reg;
  // Pass-thru would expose partial packets, so it is always off in this mode.
  assign pt_active = PASS_THRU & 1'b0;

  // Commit pointer. It moves past each stored last beat.
  // When a lone oversize packet fills the FIFO, it jumps to wrptr so the stream keeps moving.
  always_ff @(posedge aclk) begin
    if (clear) begin
      commit_reg <= '0;
    end else if (push && hs.in_last) begin
      commit_reg <= wrptr_reg + PTR_ONE;
    end else if (full && (commit_reg == rdptr_reg)) begin
      commit_reg <= wrptr_reg;
    end
  end
`else
  assign vis_level = level;
  assign pt_active = PASS_THRU && (level == '0) && hs.out_ready;
`endif

  // Handshake outputs. Normally they come from the stored head. An empty FIFO in pass-thru forwards the producer directly.
  always_comb begin
    hs.in_ready  = ~full;
    hs.out_valid = (vis_level != '0);
    hs.out_data  = head[DATA_WIDTH-1:0];
    hs.out_last  = head[DATA_WIDTH];
    if (pt_active) begin
      hs.in_ready  = 1'b1;
      hs.out_valid = hs.in_valid;
      hs.out_data  = hs.in_data;
      hs.out_last  = hs.in_last;
    end
  end

  // A bypassed beat is neither stored nor counted as a pop.
  assign push = hs.in_valid & hs.in_ready & ~pt_active;
  assign pop  = hs.out_valid & hs.out_ready & ~pt_active;

  // Write and read pointer update.
  always_ff @(posedge aclk) begin
    if (clear) begin
      wrptr_reg <= '0;
      rdptr_reg <= '0;
    end else begin
      if (push) wrptr_reg <= wrptr_reg + PTR_ONE;
      if (pop)  rdptr_reg <= rdptr_reg + PTR_ONE;
    end
  end

  // Payload storage, with the last flag kept as the top bit of each entry.
  always_ff @(posedge aclk) begin
    if (push && !clear) begin
      mem_reg[wrptr_reg[ADDR_WIDTH-1:0]] <= {hs.in_last, hs.in_data};
    end
  end

endmodule

// File: tb/tb_axicb_scfifo_hs.sv
// Self-checking bench for axicb_scfifo_hs.
// Covers fill/drain, full push/pull, pointer wrap, pass-thru, flush/reset,
// and packet-store mode when AXICB_SCFIFO_PKT_EN is defined.
module tb_axicb_scfifo_hs;

`ifdef AXICB_SCFIFO_PKT_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  int tests = 0;
  int fails = 0;

  // ---------------- DUT A: depth 4, no pass-thru ----------------
  logic       a_rstn, a_srst, a_flush;
  logic [2:0] a_level;
  logic       a_af, a_ae;
  axicb_scfifo_hs_if #(.DATA_WIDTH(8)) a_if ();
  axicb_scfifo_hs #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .PASS_THRU(1'b0)) u_a (
    .aclk(aclk), .aresetn(a_rstn), .srst(a_srst), .flush(a_flush),
    .hs(a_if.slave), .level(a_level), .almost_full(a_af), .almost_empty(a_ae)
  );

`ifndef AXICB_SCFIFO_PKT_EN
  // ---------------- DUT P: depth 4, pass-thru ----------------
  logic       p_rstn, p_srst, p_flush;
  logic [2:0] p_level;
  logic       p_af, p_ae;
  axicb_scfifo_hs_if #(.DATA_WIDTH(8)) p_if ();
  axicb_scfifo_hs #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .PASS_THRU(1'b1)) u_p (
    .aclk(aclk), .aresetn(p_rstn), .srst(p_srst), .flush(p_flush),
    .hs(p_if.slave), .level(p_level), .almost_full(p_af), .almost_empty(p_ae)
  );
`else
  // ---------------- DUT K: depth 8, packet-store ----------------
  logic       k_rstn, k_srst, k_flush;
  logic [3:0] k_level;
  logic       k_af, k_ae;
  axicb_scfifo_hs_if #(.DATA_WIDTH(8)) k_if ();
  axicb_scfifo_hs #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .PASS_THRU(1'b0)) u_k (
    .aclk(aclk), .aresetn(k_rstn), .srst(k_srst), .flush(k_flush),
    .hs(k_if.slave), .level(k_level), .almost_full(k_af), .almost_empty(k_ae)
  );
`endif

  // Reference model of DUT A: an ordered queue of {last, data}, capacity 4
  logic [8:0] q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle on DUT A: drive, check at the falling edge, then advance the model
  task automatic cyc_a(input bit v, input logic [7:0] d, input bit l, input bit r,
                       input bit rstn, input bit sr, input bit fl, output bit acc);
    bit exp_ir;
    bit exp_ov;
    a_if.in_valid  = v;
    a_if.in_data   = d;
    a_if.in_last   = l;
    a_if.out_ready = r;
    a_rstn  = rstn;
    a_srst  = sr;
    a_flush = fl;
    @(negedge aclk);
    exp_ir = (q.size() < 4);
    exp_ov = (q.size() != 0);
    chk("a_level",        32'(a_level),         32'(q.size()));
    chk("a_in_ready",     32'(a_if.in_ready),   32'(exp_ir));
    chk("a_out_valid",    32'(a_if.out_valid),  32'(exp_ov));
    chk("a_almost_full",  32'(a_af),            32'(q.size() >= 3));
    chk("a_almost_empty", 32'(a_ae),            32'(q.size() <= 1));
    if (exp_ov) begin
      chk("a_out_data", 32'(a_if.out_data), 32'(q[0][7:0]));
      chk("a_out_last", 32'(a_if.out_last), 32'(q[0][8]));
    end
    acc = v && exp_ir && rstn && !sr && !fl;
    if (exp_ov && r)
      $display("[TB] a pop data=0x%02h last=%0d level=%0d", a_if.out_data, a_if.out_last, a_level);
    @(posedge aclk);
    #1;
    if (!rstn || sr || fl) begin
      q.delete();
    end else begin
      if (exp_ov && r) void'(q.pop_front());
      if (v && exp_ir) q.push_back({l, d});
    end
  endtask

  task automatic drain_a();
    bit acc;
    for (int k = 0; k < 12 && q.size() > 0; k++) cyc_a(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, acc);
    cyc_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
  endtask

  task automatic fill_a(input int n, input logic [7:0] base);
    bit acc;
    for (int i = 0; i < n; i++) cyc_a(1'b1, base + 8'(i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, acc);
  endtask

  initial begin
    bit         acc;
    int         sent;
    bit         pv;
    logic [7:0] pd;
    bit         pl;
    logic [7:0] nxt;

    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.in_last = 1'b0; a_if.out_ready = 1'b0;
    a_rstn = 1'b0; a_srst = 1'b0; a_flush = 1'b0;
`ifndef AXICB_SCFIFO_PKT_EN
    p_if.in_valid = 1'b0; p_if.in_data = '0; p_if.in_last = 1'b0; p_if.out_ready = 1'b0;
    p_rstn = 1'b0; p_srst = 1'b0; p_flush = 1'b0;
`else
    k_if.in_valid = 1'b0; k_if.in_data = '0; k_if.in_last = 1'b0; k_if.out_ready = 1'b0;
    k_rstn = 1'b0; k_srst = 1'b0; k_flush = 1'b0;
`endif
    repeat (2) @(posedge aclk);
    #1;
    a_rstn = 1'b1;
`ifndef AXICB_SCFIFO_PKT_EN
    p_rstn = 1'b1;
`else
    k_rstn = 1'b1;
`endif

    // Reset state and fill/drain of 0xA0..0xA3
    for (int i = 0; i < 4; i++)
      cyc_a(1'b1, 8'hA0 + 8'(i), PKT ? 1'b1 : (i == 3), 1'b0, 1'b1, 1'b0, 1'b0, acc);
    cyc_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    drain_a();

    // Full with simultaneous push/pull for 20 cycles
    fill_a(4, 8'hB0);
    nxt = 8'hB4;
    for (int i = 0; i < 20; i++) begin
      cyc_a(1'b1, nxt, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, acc);
      if (acc) nxt++;
    end
    drain_a();

    // Pointer wrap: 37 random beats with random valid/ready; data held while stalled
    sent = 0;
    pv   = 1'b0;
    pd   = '0;
    pl   = 1'b0;
    for (int c = 0; c < 2000 && sent < 37; c++) begin
      if (!pv) begin
        pv = 1'($urandom_range(0, 1));
        pd = 8'($urandom);
        pl = PKT ? 1'b1 : 1'($urandom);
      end
      cyc_a(pv, pd, pl, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, acc);
      if (acc) begin
        sent++;
        pv = 1'b0;
      end
    end
    chk("wrap_beats_sent", 32'(sent), 32'd37);
    drain_a();

    // Flush with level 3 and a concurrent handshake; then aresetn, then srst
    fill_a(3, 8'hC0);
    cyc_a(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, acc);
    cyc_a(1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    drain_a();
    fill_a(3, 8'hD0);
    cyc_a(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    cyc_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    fill_a(2, 8'hE0);
    cyc_a(1'b1, 8'hEE, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    cyc_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, acc);

`ifndef AXICB_SCFIFO_PKT_EN
    // Pass-thru: an empty FIFO with out_ready forwards in the same cycle
    p_if.in_valid = 1'b1; p_if.in_data = 8'h5C; p_if.in_last = 1'b1; p_if.out_ready = 1'b1;
    @(negedge aclk);
    chk("pt_out_valid", 32'(p_if.out_valid), 32'd1);
    chk("pt_out_data",  32'(p_if.out_data),  32'h5C);
    chk("pt_out_last",  32'(p_if.out_last),  32'd1);
    chk("pt_in_ready",  32'(p_if.in_ready),  32'd1);
    chk("pt_level",     32'(p_level),        32'd0);
    $display("[TB] p pass-thru data=0x%02h", p_if.out_data);
    @(posedge aclk); #1;
    p_if.in_valid = 1'b1; p_if.in_data = 8'h11; p_if.in_last = 1'b0; p_if.out_ready = 1'b0;
    @(negedge aclk);
    chk("pt_level_after", 32'(p_level),       32'd0);
    chk("pt_nopt_valid",  32'(p_if.out_valid), 32'd0);
    @(posedge aclk); #1;
    p_if.in_valid = 1'b1; p_if.in_data = 8'h22; p_if.in_last = 1'b1; p_if.out_ready = 1'b1;
    @(negedge aclk);
    chk("pt_stored_level", 32'(p_level),        32'd1);
    chk("pt_stored_data",  32'(p_if.out_data),  32'h11);
    chk("pt_stored_last",  32'(p_if.out_last),  32'd0);
    @(posedge aclk); #1;
    p_if.in_valid = 1'b0; p_if.out_ready = 1'b1;
    @(negedge aclk);
    chk("pt_second_level", 32'(p_level),       32'd1);
    chk("pt_second_data",  32'(p_if.out_data), 32'h22);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("pt_final_level", 32'(p_level), 32'd0);
`else
    begin
      int got;
      int idx;
      // 3-beat packet: invisible until the last beat is stored
      k_if.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        k_if.in_valid = 1'b1; k_if.in_data = 8'h10 + 8'(i); k_if.in_last = (i == 2);
        @(negedge aclk);
        chk("pkt_hidden_valid", 32'(k_if.out_valid), 32'd0);
        @(posedge aclk); #1;
      end
      k_if.in_valid = 1'b0;
      @(negedge aclk);
      chk("pkt_visible_valid", 32'(k_if.out_valid), 32'd1);
      chk("pkt_level3",        32'(k_level),        32'd3);
      @(posedge aclk); #1;
      k_if.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge aclk);
        chk("pkt3_data", 32'(k_if.out_data), 32'h10 + 32'(i));
        chk("pkt3_last", 32'(k_if.out_last), 32'(i == 2));
        $display("[TB] k pop data=0x%02h last=%0d", k_if.out_data, k_if.out_last);
        @(posedge aclk); #1;
      end
      k_if.out_ready = 1'b0;
      @(negedge aclk);
      chk("pkt3_empty", 32'(k_level), 32'd0);
      @(posedge aclk); #1;

      // 10-beat oversize packet: force-commit once full, then cut-through drain
      for (int i = 0; i < 8; i++) begin
        k_if.in_valid = 1'b1; k_if.in_data = 8'h40 + 8'(i); k_if.in_last = 1'b0;
        @(negedge aclk);
        chk("pkt10_fill_ready", 32'(k_if.in_ready), 32'd1);
        @(posedge aclk); #1;
      end
      k_if.in_data = 8'h48;
      @(negedge aclk);
      chk("pkt10_full_ready", 32'(k_if.in_ready),  32'd0);
      chk("pkt10_full_level", 32'(k_level),        32'd8);
      chk("pkt10_pre_force",  32'(k_if.out_valid), 32'd0);
      @(posedge aclk); #1;
      @(negedge aclk);
      chk("pkt10_forced", 32'(k_if.out_valid), 32'd1);
      @(posedge aclk); #1;
      got = 0;
      idx = 8;
      k_if.out_ready = 1'b1;
      for (int c = 0; c < 60 && got < 10; c++) begin
        k_if.in_valid = (idx < 10);
        k_if.in_data  = 8'h40 + 8'(idx);
        k_if.in_last  = (idx == 9);
        @(negedge aclk);
        if (k_if.out_valid) begin
          chk("pkt10_data", 32'(k_if.out_data), 32'h40 + 32'(got));
          chk("pkt10_last", 32'(k_if.out_last), 32'(got == 9));
          $display("[TB] k pop data=0x%02h last=%0d", k_if.out_data, k_if.out_last);
          got++;
        end
        if (k_if.in_valid && k_if.in_ready) idx++;
        @(posedge aclk); #1;
      end
      chk("pkt10_all_beats", 32'(got), 32'd10);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
